// File: rtl/mem_interface.sv
// -----------------------------------------------------------------------------
// mem_interface
//
// Memory-side stage behind the datapath MAR/MDR pair. It owns the memory
// address register (MAR), the memory data register (MDR) and a word-addressed
// on-chip RAM. It runs multi-cycle reads and writes under a read/write/done
// handshake with the control unit.
//
// Parameters
//   ADDR_W      : RAM address width; MAR holds i_bus_data[ADDR_W-1:0]
//   DATA_W      : word width
//   MEM_WORDS   : RAM depth (<= 2**ADDR_W); addresses at or above it are
//                 out of range
//   WAIT_CYCLES : access latency in clock edges (>= 1)
//
// Ports
//   i_clk       : single clock, all state changes on the rising edge
//   i_clr       : synchronous active-high reset, priority over everything
//   i_mar_in    : load MAR from the bus (IDLE only)
//   i_mdr_in    : load MDR from the bus (IDLE only)
//   i_read      : start a read of mem[MAR] into MDR
//   i_write     : start a write of MDR into mem[MAR]
//   i_bus_data  : datapath bus
//   o_mar_out   : current MAR
//   o_mdr_out   : current MDR, feeds the bus mux
//   o_busy      : an access is in progress
//   o_done      : one-cycle pulse when an access completes
//   o_err       : sticky error (read+write together, or out-of-range access)
// -----------------------------------------------------------------------------
module mem_interface #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_mar_in,
    input  logic              i_mdr_in,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [ADDR_W-1:0] o_mar_out,
    output logic [DATA_W-1:0] o_mdr_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // A one-cycle latency still needs a one-bit counter to hold the value 0.
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    // Address/data snapshot taken when a request is accepted. A MAR/MDR load
    // on the request edge must not leak into the access, so the access runs
    // on the values that were present just before that edge.
    logic [ADDR_W-1:0]   r_acc_addr;
    logic [DATA_W-1:0]   r_acc_data;

    logic [DATA_W-1:0]   r_mem [0:MEM_WORDS-1];

    logic                w_load_mar;
    logic                w_load_mdr;
    logic                w_start;
    logic                w_commit_rd;
    logic                w_commit_wr;
    logic                w_err_set;
    logic                w_busy_next;
    logic                w_done_next;
    logic                w_in_range;
    logic [MEM_AW-1:0]   w_mem_idx;

    assign w_in_range = ({1'b0, r_acc_addr} < MEM_LIMIT);
    assign w_mem_idx  = r_acc_addr[MEM_AW-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_load_mar   = 1'b0;
        w_load_mdr   = 1'b0;
        w_start      = 1'b0;
        w_commit_rd  = 1'b0;
        w_commit_wr  = 1'b0;
        w_err_set    = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_load_mar = i_mar_in;
                w_load_mdr = i_mdr_in;
                if (i_read) begin
                    // Read wins a simultaneous request; the write is dropped.
                    w_next_state = S_READ;
                    w_cnt_next   = CNT_LOAD;
                    w_start      = 1'b1;
                    w_busy_next  = 1'b1;
                    w_err_set    = i_write;
                end else if (i_write) begin
                    w_next_state = S_WRITE;
                    w_cnt_next   = CNT_LOAD;
                    w_start      = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end

            S_READ, S_WRITE: begin
                if (r_cnt != '0) begin
                    w_cnt_next  = r_cnt - CNT_W'(1);
                    w_busy_next = 1'b1;
                end else begin
                    // Commit edge: back to IDLE so the done cycle can
                    // accept the next request.
                    w_next_state = S_IDLE;
                    w_done_next  = 1'b1;
                    w_commit_rd  = (r_state == S_READ);
                    w_commit_wr  = (r_state == S_WRITE);
                    w_err_set    = !w_in_range;
                end
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MAR / MDR / status registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_mar      <= '0;
            r_mdr      <= '0;
            r_acc_addr <= '0;
            r_acc_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_load_mar) begin
                r_mar <= i_bus_data[ADDR_W-1:0];
            end
            if (w_load_mdr) begin
                r_mdr <= i_bus_data;
            end
            if (w_start) begin
                r_acc_addr <= r_mar;
                r_acc_data <= r_mdr;
            end
            // Loads happen only in IDLE and commits only in READ, so the two
            // MDR writers never collide.
            if (w_commit_rd) begin
                r_mdr <= w_in_range ? r_mem[w_mem_idx] : '0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    // NOTE: the RAM array has no reset so it maps onto plain memory macros;
    // a reset only aborts a pending write, it never clears contents.
    always_ff @(posedge i_clk) begin
        if (!i_clr && w_commit_wr && w_in_range) begin
            r_mem[w_mem_idx] <= r_acc_data;
        end
    end

    assign o_mar_out = r_mar;
    assign o_mdr_out = r_mdr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule
